nbit_mux_stage: RTL
===================

Name: nbit_mux_stage

Overview:
Parametrised M-way, N-bit select stage that registers the selected operand into a pipeline register with a valid/ready handshake and a 2-entry skid buffer. It generalises the 2:1 combinational operand mux to arbitrary input count and adds stall, flush and back-pressure handling. It sits at pipeline stage boundaries, for example forwarding-source select into ID/EX, so that stalls do not drop or duplicate operands.

Parameters:
N, 32, data width in bits
M, 4, number of input channels (2..16)
SELW, $clog2(M) (minimum 1), select width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_data  input  M*N  packed channels; channel k occupies bits [k*N +: N]
sel  input  SELW  channel select, sampled with in_valid
in_valid  input  1  upstream data valid
in_ready  output  1  stage can accept; registered
flush  input  1  synchronous pipeline flush
out_data  output  N  head-entry data; registered
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state EMPTY, out_valid=0, out_data=0, in_ready=1, skid register=0.
- Selected word: in_data[sel*N +: N] when sel < M; all-zero when sel >= M. A sel value of M or above is legal and is not an error.
- Accept condition: in_valid && in_ready. Deliver condition: out_valid && out_ready.
- Latency: an accepted word appears on out_data/out_valid on the next rising edge when the stage was EMPTY, or the stage was ONE and delivered that cycle.
- States:
  - EMPTY: head and skid both invalid.
  - ONE: head valid.
  - FULL: head and skid valid.
- Transitions, evaluated when flush=0:
  - EMPTY + accept -> ONE; head <= selected word.
  - ONE + accept + deliver -> ONE; head <= selected word.
  - ONE + accept + no deliver -> FULL; skid <= selected word.
  - ONE + deliver + no accept -> EMPTY.
  - FULL + deliver -> ONE; head <= skid. No accept is possible here because in_ready=0.
  - All other combinations hold the current state.
- in_ready = (next state != FULL), registered. It is 0 only while in FULL.
- Ordering: strict FIFO. No word is dropped or duplicated under any out_ready pattern.
- out_data holds its value while out_valid=1 and out_ready=0. It also holds its last value when the stage goes EMPTY; it is not cleared.
- Flush:
  - flush=1 at a rising edge forces EMPTY, out_valid=0, in_ready=1.
  - A simultaneous accept is discarded.
  - A simultaneous deliver still counts for downstream, since downstream sampled it that cycle.
  - Flush has priority over all other transitions.
- Reset mid-operation: asynchronous return to reset values. Any pending words are lost.
- The design holds no combinational path from in_valid/out_ready to in_ready.

Optional Feature:
Macro: NBIT_MUX_STAGE_PARITY_EN.
- When defined:
  - Extra output port out_parity, 1 bit, equal to the even parity (XOR reduction) of out_data.
  - Parity is computed at capture and stored alongside each entry, head and skid alike, so it moves with the data.
  - Reset value 0. Flush does not clear it.
- When undefined: the port is absent and there is no parity storage.

Test Plan:
1. Reset with rst=1 mid-stream while FULL -> out_valid=0, in_ready=1, out_data=0 immediately, without waiting for a clock edge.
2. M=4, N=32, channels = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1, out_ready=1 -> out_data=0x33333333 and out_valid=1 one cycle later. Throughput is 1 word per cycle across sel=0..3.
3. Stall: out_ready=0; push A=0xA, B=0xB -> after the 2nd accept in_ready=0 (FULL) and out_data=0xA. Raise out_ready -> delivers 0xA then 0xB in order, and in_ready returns to 1 after the first deliver.
4. Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered word never appears on the output.
5. M=3, sel=3 with in_valid=1 -> out_data=0, out_valid=1.
6. With NBIT_MUX_STAGE_PARITY_EN: word 0x00000007 -> out_parity=1; word 0x00000003 -> out_parity=0. Parity stays aligned with data through a FULL/skid sequence.

Source files
------------

// File: rtl/nbit_mux_stage.sv
// M-way, N-bit operand select registered into a pipeline stage with valid/ready and a 2-entry skid buffer.
// Optional per-entry parity output is built when NBIT_MUX_STAGE_PARITY_EN is defined.
module nbit_mux_stage #(
    parameter int N    = 32,
    parameter int M    = 4,
    parameter int SELW = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [M*N-1:0]    in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef NBIT_MUX_STAGE_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    // state | meaning
    // EMPTY | head and skid both invalid
    // ONE   | head valid, skid invalid
    // FULL  | head and skid valid, upstream stalled
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [N-1:0] head_q;
    logic [N-1:0] skid_q;
    logic         in_ready_q;
    logic [N-1:0] sel_word;
    logic         accept;
    logic         deliver;
    logic         load_head_sel;
    logic         load_head_skid;
    logic         load_skid;

    // Out-of-range select values yield zero rather than aliasing a channel.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < M; k++) begin
            if (sel == SELW'(k)) begin
                sel_word = in_data[k*N +: N];
            end
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = head_q;
    assign accept    = in_valid && in_ready_q;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_sel  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d       = ONE;
                        load_head_sel = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_head_sel = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_d        = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is a flop of the next state so no input reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (load_head_sel) begin
                head_q <= sel_word;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= sel_word;
            end
        end
    end

`ifdef NBIT_MUX_STAGE_PARITY_EN
    logic head_par_q;
    logic skid_par_q;

    // Parity travels with its entry so a skid-to-head move keeps it aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (load_head_sel) begin
                head_par_q <= ^sel_word;
            end else if (load_head_skid) begin
                head_par_q <= skid_par_q;
            end
            if (load_skid) begin
                skid_par_q <= ^sel_word;
            end
        end
    end

    assign out_parity = head_par_q;
`endif

endmodule
